// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: pops ASCII command bytes from the UART RX FIFO and turns
// them into single-cycle command pulses for the watch/sensor logic.
// Unknown bytes bump a saturating error counter.
//
// Build option UART_CMD_ECHO_EN: when defined, every non-CR/LF byte is echoed
// to the TX FIFO (upper-cased command, or NAK_CHAR for unknown bytes).
// When undefined, the echo path is absent and the TX outputs are tied low.
//
// Timing per byte: pop in IDLE, pulse visible during EXEC, echo push during
// ECHO. So the pulse is one cycle after the pop, and the push is one cycle
// after the pulse when TX is not full.

module uart_cmd_decoder #(
    parameter int unsigned ERR_W    = 8,
    parameter logic [7:0]  NAK_CHAR = 8'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_empty,
    input  logic [7:0]       rx_rdata,
    output logic             rx_pop,
    input  logic             tx_full,
    output logic             tx_push,
    output logic [7:0]       tx_wdata,
    output logic             cmd_btn_l,
    output logic             cmd_btn_r,
    output logic             cmd_btn_u,
    output logic             cmd_btn_d,
    output logic             cmd_mode,
    output logic             cmd_time,
    output logic             cmd_clear,
    output logic             cmd_sr04,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1
`ifdef UART_CMD_ECHO_EN
        , S_ECHO = 2'd2
`endif
    } state_t;

    // Pulse vector bit order: L, R, U, D, M, H, S, T (bit 0 .. bit 7).
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_U = 8'h55;
    localparam logic [7:0] CH_D = 8'h44;
    localparam logic [7:0] CH_M = 8'h4D;
    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Lower-case letters map to upper case by clearing bit 5; other bytes pass.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= 8'h61 && b <= 8'h7A) r = b & 8'hDF;
        return r;
    endfunction

    // One-hot command decode; zero for anything unrecognised.
    function automatic logic [7:0] decode(input logic [7:0] b);
        logic [7:0] hit;
        hit = 8'h00;
        case (to_upper(b))
            CH_L:    hit = 8'h01;
            CH_R:    hit = 8'h02;
            CH_U:    hit = 8'h04;
            CH_D:    hit = 8'h08;
            CH_M:    hit = 8'h10;
            CH_H:    hit = 8'h20;
            CH_S:    hit = 8'h40;
            CH_T:    hit = 8'h80;
            default: hit = 8'h00;
        endcase
        return hit;
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic [7:0]       pulse_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic [7:0]       rx_hit;
    logic             cmd_known;
    logic             cmd_eol;

    assign rx_hit    = decode(rx_rdata);
    assign cmd_known = |decode(cmd_q);
    assign cmd_eol   = is_eol(cmd_q);
    // Counter holds at all-ones instead of wrapping.
    assign err_d     = (err_q == '1) ? err_q : err_q + ERR_W'(1);

    // Pop is the only combinational output so a waiting byte costs no extra cycle.
    assign rx_pop = (state_q == S_IDLE) && !rx_empty;

`ifdef UART_CMD_ECHO_EN
    logic       push_q;
    logic [7:0] wdata_q;

    // Decoder FSM with echo: IDLE -> EXEC -> (ECHO) -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 8'h00;
            pulse_q <= 8'h00;
            err_q   <= '0;
            push_q  <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            pulse_q <= 8'h00;
            case (state_q)
                S_IDLE: begin
                    if (!rx_empty) begin
                        cmd_q   <= rx_rdata;
                        // Pulse is decoded at the pop so it is visible during EXEC.
                        pulse_q <= rx_hit;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!cmd_known && !cmd_eol) err_q <= err_d;
                    if (cmd_eol) begin
                        state_q <= S_IDLE;
                    end else begin
                        wdata_q <= cmd_known ? to_upper(cmd_q) : NAK_CHAR;
                        push_q  <= !tx_full;
                        state_q <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    // push_q high means the push is on the bus this cycle.
                    if (push_q) begin
                        push_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!tx_full) begin
                        push_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_push  = push_q;
    assign tx_wdata = wdata_q;
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_full;

    // Decoder FSM without echo: IDLE -> EXEC -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 8'h00;
            pulse_q <= 8'h00;
            err_q   <= '0;
        end else begin
            pulse_q <= 8'h00;
            case (state_q)
                S_IDLE: begin
                    if (!rx_empty) begin
                        cmd_q   <= rx_rdata;
                        pulse_q <= rx_hit;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!cmd_known && !cmd_eol) err_q <= err_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_push  = 1'b0;
    assign tx_wdata = 8'h00;
`endif

    assign cmd_btn_l = pulse_q[0];
    assign cmd_btn_r = pulse_q[1];
    assign cmd_btn_u = pulse_q[2];
    assign cmd_btn_d = pulse_q[3];
    assign cmd_mode  = pulse_q[4];
    assign cmd_time  = pulse_q[5];
    assign cmd_clear = pulse_q[6];
    assign cmd_sr04  = pulse_q[7];
    assign err_cnt   = err_q;

    // At most one command pulse at a time, never alongside a pop.
    a_onehot_pulse: assert property (@(posedge clk) disable iff (rst) $onehot0(pulse_q));
    a_no_pop_overlap: assert property (@(posedge clk) disable iff (rst) !(rx_pop && (pulse_q != 8'h00)));

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder. A queue models the RX FIFO; a
// per-cycle monitor records pops, pulses and pushes; each scenario pushes its
// expected pulses/echo bytes and compares them against the recorded events.
// Works in both builds; echo expectations follow UART_CMD_ECHO_EN.

module tb_uart_cmd_decoder;

    localparam int ERR_W = 8;
`ifdef UART_CMD_ECHO_EN
    localparam int BYTE_CYC = 3;
`else
    localparam int BYTE_CYC = 2;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_empty = 1'b1;
    logic [7:0]       rx_rdata = 8'h00;
    logic             tx_full = 1'b0;
    logic             rx_pop, tx_push;
    logic [7:0]       tx_wdata;
    logic             cmd_btn_l, cmd_btn_r, cmd_btn_u, cmd_btn_d;
    logic             cmd_mode, cmd_time, cmd_clear, cmd_sr04;
    logic [ERR_W-1:0] err_cnt;

    uart_cmd_decoder #(.ERR_W(ERR_W), .NAK_CHAR(8'h3F)) dut (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_pop(rx_pop),
        .tx_full(tx_full), .tx_push(tx_push), .tx_wdata(tx_wdata),
        .cmd_btn_l(cmd_btn_l), .cmd_btn_r(cmd_btn_r),
        .cmd_btn_u(cmd_btn_u), .cmd_btn_d(cmd_btn_d),
        .cmd_mode(cmd_mode), .cmd_time(cmd_time),
        .cmd_clear(cmd_clear), .cmd_sr04(cmd_sr04),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         overlap_cnt = 0;
    logic [7:0] rxq[$];
    ev_t        obs_pulse[$];
    ev_t        obs_tx[$];
    int         obs_pop[$];
    logic [7:0] exp_pulse[$];
    logic [7:0] exp_tx[$];

    function automatic logic [7:0] pulses();
        return {cmd_sr04, cmd_clear, cmd_time, cmd_mode,
                cmd_btn_d, cmd_btn_u, cmd_btn_r, cmd_btn_l};
    endfunction

    task automatic drive_rx();
        rx_empty = (rxq.size() == 0);
        rx_rdata = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic fifo_push(input logic [7:0] b);
        rxq.push_back(b);
        drive_rx();
    endtask

    task automatic clear_obs();
        obs_pulse.delete(); obs_tx.delete(); obs_pop.delete();
        exp_pulse.delete(); exp_tx.delete();
        overlap_cnt = 0;
    endtask

    // One clock: sample at negedge, let the FIFO model follow any pop after posedge.
    task automatic tick();
        logic [7:0] p;
        logic       popn;
        ev_t        e;
        @(negedge clk);
        p = pulses();
        if (p != 8'h00) begin e.cyc = cyc; e.val = p; obs_pulse.push_back(e); end
        if (rx_pop) obs_pop.push_back(cyc);
        if (rx_pop && p != 8'h00) overlap_cnt++;
        if (tx_push) begin e.cyc = cyc; e.val = tx_wdata; obs_tx.push_back(e); end
        popn = rx_pop;
        @(posedge clk); #1;
        cyc++;
        if (popn && rxq.size() > 0) void'(rxq.pop_front());
        drive_rx();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (rxq.size() != 0 && n < max_cyc) begin tick(); n++; end
        checks++;
        if (rxq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes left, want 0", rxq.size());
        end
        repeat (6) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rxq.delete();
        drive_rx();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
        checks++; if (tx_push !== 1'b0) begin errors++; $display("FAIL reset_tx_push: got %b want 0", tx_push); end
        checks++; if (tx_wdata !== 8'h00) begin errors++; $display("FAIL reset_tx_wdata: got %h want 00", tx_wdata); end
        checks++; if (pulses() !== 8'h00) begin errors++; $display("FAIL reset_pulses: got %h want 00", pulses()); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_m();
        int pop_c, pul_c;
        ev_t o;
        logic [7:0] e;
        clear_obs();
        fifo_push(8'h4D);
        exp_pulse.push_back(8'h10);
`ifdef UART_CMD_ECHO_EN
        exp_tx.push_back(8'h4D);
`endif
        drain(20);
        pop_c = (obs_pop.size() > 0) ? obs_pop[0] : -100;
        pul_c = (obs_pulse.size() > 0) ? obs_pulse[0].cyc : -100;
        checks++; if (obs_pop.size() != 1) begin errors++; $display("FAIL m_pop_count: got %0d want 1", obs_pop.size()); end
        checks++; if (pul_c != pop_c + 1) begin errors++; $display("FAIL m_pulse_latency: got cyc %0d want %0d", pul_c, pop_c + 1); end
`ifdef UART_CMD_ECHO_EN
        checks++;
        if (obs_tx.size() == 0 || obs_tx[0].cyc != pul_c + 1) begin
            errors++; $display("FAIL m_echo_latency: got %0d pushes, want push at cyc %0d", obs_tx.size(), pul_c + 1);
        end
`endif
        while (exp_pulse.size() > 0) begin
            e = exp_pulse.pop_front(); checks++;
            if (obs_pulse.size() == 0) begin errors++; $display("FAIL m_pulse: got none want %h", e); end
            else begin o = obs_pulse.pop_front(); if (o.val !== e) begin errors++; $display("FAIL m_pulse: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_pulse.size() != 0) begin errors++; $display("FAIL m_extra_pulse: got %0d extra want 0", obs_pulse.size()); end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL m_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL m_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL m_extra_echo: got %0d extra want 0", obs_tx.size()); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL m_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        ev_t o;
        logic [7:0] e;
        clear_obs();
        fifo_push(8'h6D); fifo_push(8'h54); fifo_push(8'h78);
        exp_pulse.push_back(8'h10); exp_pulse.push_back(8'h80);
`ifdef UART_CMD_ECHO_EN
        exp_tx.push_back(8'h4D); exp_tx.push_back(8'h54); exp_tx.push_back(8'h3F);
`endif
        drain(40);
        checks++;
        if (obs_pop.size() != 3 || obs_pop[1] - obs_pop[0] != BYTE_CYC || obs_pop[2] - obs_pop[1] != BYTE_CYC) begin
            errors++; $display("FAIL b2b_pop_spacing: got %0d pops, want 3 spaced %0d", obs_pop.size(), BYTE_CYC);
        end
`ifdef UART_CMD_ECHO_EN
        checks++;
        if (obs_tx.size() != 3 || obs_tx[1].cyc - obs_tx[0].cyc != 3 || obs_tx[2].cyc - obs_tx[1].cyc != 3) begin
            errors++; $display("FAIL b2b_echo_spacing: got %0d pushes, want 3 spaced 3", obs_tx.size());
        end
`endif
        while (exp_pulse.size() > 0) begin
            e = exp_pulse.pop_front(); checks++;
            if (obs_pulse.size() == 0) begin errors++; $display("FAIL b2b_pulse: got none want %h", e); end
            else begin o = obs_pulse.pop_front(); if (o.val !== e) begin errors++; $display("FAIL b2b_pulse: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_pulse.size() != 0) begin errors++; $display("FAIL b2b_extra_pulse: got %0d extra want 0", obs_pulse.size()); end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL b2b_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL b2b_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL b2b_extra_echo: got %0d extra want 0", obs_tx.size()); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL b2b_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL b2b_pop_overlap: got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_tx_stall();
        int drop_c;
        ev_t o;
        logic [7:0] e;
        clear_obs();
        tx_full = 1'b1;
        fifo_push(8'h52); fifo_push(8'h4C);
        exp_pulse.push_back(8'h02); exp_pulse.push_back(8'h01);
`ifdef UART_CMD_ECHO_EN
        exp_tx.push_back(8'h52); exp_tx.push_back(8'h4C);
`endif
        repeat (10) tick();
        checks++;
        if (obs_pulse.size() == 0 || obs_pop.size() == 0 || obs_pulse[0].cyc != obs_pop[0] + 1) begin
            errors++; $display("FAIL stall_pulse_immediate: got %0d pulses, want R one cycle after pop", obs_pulse.size());
        end
`ifdef UART_CMD_ECHO_EN
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL stall_push_held: got %0d pushes want 0", obs_tx.size()); end
        checks++; if (obs_pop.size() != 1) begin errors++; $display("FAIL stall_no_next_pop: got %0d pops want 1", obs_pop.size()); end
        checks++; if (tx_wdata !== 8'h52) begin errors++; $display("FAIL stall_wdata_stable: got %h want 52", tx_wdata); end
`endif
        drop_c = cyc;
        tx_full = 1'b0;
        drain(40);
`ifdef UART_CMD_ECHO_EN
        checks++;
        if (obs_tx.size() == 0 || obs_tx[0].cyc != drop_c + 1) begin
            errors++; $display("FAIL stall_push_after_drop: got %0d pushes, want first at cyc %0d", obs_tx.size(), drop_c + 1);
        end
        checks++;
        if (obs_pop.size() != 2 || obs_pop[1] != drop_c + 2) begin
            errors++; $display("FAIL stall_next_pop: got %0d pops, want second at cyc %0d", obs_pop.size(), drop_c + 2);
        end
`else
        checks++;
        if (obs_pop.size() != 2 || obs_pop[1] != obs_pop[0] + 2) begin
            errors++; $display("FAIL stall_next_pop: got %0d pops, want second 2 cycles after first", obs_pop.size());
        end
`endif
        while (exp_pulse.size() > 0) begin
            e = exp_pulse.pop_front(); checks++;
            if (obs_pulse.size() == 0) begin errors++; $display("FAIL stall_pulse: got none want %h", e); end
            else begin o = obs_pulse.pop_front(); if (o.val !== e) begin errors++; $display("FAIL stall_pulse: got %h want %h", o.val, e); end end
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL stall_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL stall_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL stall_extra_echo: got %0d extra want 0", obs_tx.size()); end
    endtask

    task automatic test_err_saturate();
        ev_t o;
        logic [7:0] e;
        int start_err;
        int want_err;
        clear_obs();
        start_err = int'(err_cnt);
        want_err  = (start_err + 300 > 255) ? 255 : start_err + 300;
        for (int i = 0; i < 300; i++) begin
            fifo_push(8'h21);
`ifdef UART_CMD_ECHO_EN
            exp_tx.push_back(8'h3F);
`endif
        end
        drain(2000);
        checks++; if (int'(err_cnt) != want_err) begin errors++; $display("FAIL sat_err_cnt: got %0d want %0d", err_cnt, want_err); end
        checks++; if (obs_pulse.size() != 0) begin errors++; $display("FAIL sat_no_pulse: got %0d pulses want 0", obs_pulse.size()); end
        checks++; if (obs_pop.size() != 300) begin errors++; $display("FAIL sat_pop_count: got %0d want 300", obs_pop.size()); end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL sat_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL sat_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL sat_extra_echo: got %0d extra want 0", obs_tx.size()); end
    endtask

    task automatic test_crlf();
        ev_t o;
        logic [7:0] e;
        apply_reset();
        clear_obs();
        fifo_push(8'h0D); fifo_push(8'h0A); fifo_push(8'h73);
        exp_pulse.push_back(8'h40);
`ifdef UART_CMD_ECHO_EN
        exp_tx.push_back(8'h53);
`endif
        drain(30);
        checks++; if (obs_pop.size() != 3) begin errors++; $display("FAIL crlf_pop_count: got %0d want 3", obs_pop.size()); end
        checks++;
        if (obs_pulse.size() == 0 || obs_pop.size() != 3 || obs_pulse[0].cyc != obs_pop[2] + 1) begin
            errors++; $display("FAIL crlf_pulse_timing: got %0d pulses, want only after third pop", obs_pulse.size());
        end
        while (exp_pulse.size() > 0) begin
            e = exp_pulse.pop_front(); checks++;
            if (obs_pulse.size() == 0) begin errors++; $display("FAIL crlf_pulse: got none want %h", e); end
            else begin o = obs_pulse.pop_front(); if (o.val !== e) begin errors++; $display("FAIL crlf_pulse: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_pulse.size() != 0) begin errors++; $display("FAIL crlf_extra_pulse: got %0d extra want 0", obs_pulse.size()); end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL crlf_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL crlf_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL crlf_extra_echo: got %0d extra want 0", obs_tx.size()); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL crlf_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_reset_in_echo();
        ev_t o;
        logic [7:0] e;
        logic [23:0] outs;
        clear_obs();
        tx_full = 1'b1;
        fifo_push(8'h64);
        repeat (4) tick();
        checks++;
        if (obs_pulse.size() != 1 || obs_pulse[0].val !== 8'h08) begin
            errors++; $display("FAIL rst_pre_pulse: got %0d pulses, want one D pulse", obs_pulse.size());
        end
`ifdef UART_CMD_ECHO_EN
        checks++; if (tx_wdata !== 8'h44) begin errors++; $display("FAIL rst_pre_wdata: got %h want 44", tx_wdata); end
`endif
        rst = 1'b1;
        #1;
        outs = {rx_pop, tx_push, tx_wdata, pulses(), err_cnt[5:0]};
        checks++; if (outs !== 24'h0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_outputs_zero: got %h/%0d want 0", outs, err_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_full = 1'b0;
        clear_obs();
        repeat (5) tick();
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL rst_no_push_after: got %0d pushes want 0", obs_tx.size()); end
        fifo_push(8'h55);
        exp_pulse.push_back(8'h04);
`ifdef UART_CMD_ECHO_EN
        exp_tx.push_back(8'h55);
`endif
        drain(20);
        checks++;
        if (obs_pulse.size() == 0 || obs_pop.size() != 1 || obs_pulse[0].cyc != obs_pop[0] + 1) begin
            errors++; $display("FAIL rst_u_timing: got %0d pulses, want one cycle after pop", obs_pulse.size());
        end
        while (exp_pulse.size() > 0) begin
            e = exp_pulse.pop_front(); checks++;
            if (obs_pulse.size() == 0) begin errors++; $display("FAIL rst_u_pulse: got none want %h", e); end
            else begin o = obs_pulse.pop_front(); if (o.val !== e) begin errors++; $display("FAIL rst_u_pulse: got %h want %h", o.val, e); end end
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front(); checks++;
            if (obs_tx.size() == 0) begin errors++; $display("FAIL rst_u_echo: got none want %h", e); end
            else begin o = obs_tx.pop_front(); if (o.val !== e) begin errors++; $display("FAIL rst_u_echo: got %h want %h", o.val, e); end end
        end
        checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL rst_u_extra_echo: got %0d extra want 0", obs_tx.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_m();
        test_back_to_back();
        test_tx_stall();
        test_err_saturate();
        test_crlf();
        test_reset_in_echo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Command decoder between the UART receive FIFO and the watch/sensor control logic of `final_top`. It pops ASCII command bytes from the RX FIFO and issues single-cycle command pulses (button equivalents, mode select, clear, ultrasonic measurement start). It optionally echoes each decoded byte back through the TX FIFO. Unknown bytes are counted and answered with `?`.

## Interface

Parameters:
- `ERR_W`, default 8: width of the saturating error counter.
- `NAK_CHAR`, default 8'h3F (`?`): byte echoed for an unrecognised command.

Ports:
- `clk`, input, 1: system clock (100 MHz).
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_empty`, input, 1: RX FIFO empty flag.
- `rx_rdata`, input, 8: RX FIFO head byte. First-word-fall-through: valid whenever `rx_empty`=0.
- `rx_pop`, output, 1: RX FIFO pop strobe, one cycle per byte.
- `tx_full`, input, 1: TX FIFO full flag.
- `tx_push`, output, 1: TX FIFO push strobe.
- `tx_wdata`, output, 8: TX FIFO write byte.
- `cmd_btn_l`, `cmd_btn_r`, `cmd_btn_u`, `cmd_btn_d`, output, 1 each: one-cycle button-equivalent pulses.
- `cmd_mode`, output, 1: one-cycle pulse, watch/stopwatch mode toggle.
- `cmd_time`, output, 1: one-cycle pulse, time-display select.
- `cmd_clear`, output, 1: one-cycle pulse, clear/reset of the active function.
- `cmd_sr04`, output, 1: one-cycle pulse, start an ultrasonic measurement.
- `err_cnt`, output, ERR_W: saturating count of unrecognised bytes.

## Operation

- Decode map (upper or lower case accepted; bit 5 is cleared before compare for letters):
  - `L` (8'h4C) -> `cmd_btn_l`
  - `R` (8'h52) -> `cmd_btn_r`
  - `U` (8'h55) -> `cmd_btn_u`
  - `D` (8'h44) -> `cmd_btn_d`
  - `M` (8'h4D) -> `cmd_mode`
  - `H` (8'h48) -> `cmd_time`
  - `S` (8'h53) -> `cmd_clear`
  - `T` (8'h54) -> `cmd_sr04`
- CR (8'h0D) and LF (8'h0A) are silently discarded: no pulse, no echo, no error count.
- Any other byte: no command pulse, `err_cnt` += 1 (saturates at all-ones), NAK.
- FSM states:
  - IDLE: when `rx_empty`=0, assert `rx_pop` combinationally, latch `rx_rdata` into `cmd_q`, go to EXEC.
  - EXEC: drive exactly one command pulse from `cmd_q`, or update `err_cnt`. Go to ECHO if echo is compiled in and the byte is not CR/LF; otherwise go to IDLE.
  - ECHO: hold while `tx_full`=1. When `tx_full`=0, assert `tx_push` for one cycle with `tx_wdata` = upper-cased command byte or `NAK_CHAR`, then go to IDLE.
- At most one command output is high in any cycle. Command pulses never overlap `rx_pop`.
- Bytes arriving while the FSM is in EXEC or ECHO stay in the RX FIFO. The block never drops a byte on its own.

## Timing

- Reset values: all pulses 0, `rx_pop`=0, `tx_push`=0, `tx_wdata`=8'h00, `err_cnt`=0, state IDLE.
- Byte pop at edge N (IDLE with `rx_empty`=0). The command pulse is high during cycle N+1. The echo push is high during cycle N+2 at the earliest.
- Throughput:
  - Echo compiled in: 3 cycles/byte when TX is not full.
  - Echo compiled out: 2 cycles/byte.
- `tx_full` stall in ECHO: the pulse has already fired. `tx_wdata` is held stable until the push.
- Reset asserted mid-ECHO: the pending echo is lost, the FSM returns to IDLE, and the RX FIFO is untouched.
- `err_cnt` saturates at 2^ERR_W−1. Further errors leave it unchanged.
- Outputs are registered except `rx_pop`, which is combinational from state and `rx_empty`.

## Configuration

- `UART_CMD_ECHO_EN`:
  - Defined: ECHO state present. Accepted commands are echoed upper-cased, unknown bytes are echoed as `NAK_CHAR`.
  - Undefined: ECHO state removed. `tx_push` is tied 0 and `tx_wdata` is tied 8'h00. `tx_full` is ignored. EXEC returns directly to IDLE.
  - Decode, pulses and `err_cnt` are identical in both builds.

## Test plan

- FIFO holds `M`. Required: `rx_pop` for one cycle, `cmd_mode`=1 for exactly one cycle on the next cycle. With echo, `tx_push` with `tx_wdata`=8'h4D one cycle later.
- Back-to-back `m`, `T`, `x` in the FIFO. Required:
  - `cmd_mode` pulse, then `cmd_sr04` pulse, no pulse for `x`.
  - `err_cnt`=1.
  - Echo stream 8'h4D, 8'h54, 8'h3F, at 3 cycles/byte.
- `R` with `tx_full`=1 held for 10 cycles. Required: `cmd_btn_r` fires at once, `tx_push` is held off, then fires with 8'h52 in the cycle after `tx_full` drops. The next byte is not popped before that push.
- 300 consecutive invalid bytes (8'h21) with ERR_W=8. Required: `err_cnt` stops at 255, and no command pulse is ever seen.
- CR, LF, then `S`. Required: two pops with no pulse, no echo and `err_cnt` unchanged, then one `cmd_clear` pulse.
- `rst` asserted in ECHO. Required: all outputs are 0 in the same cycle, with no push afterwards. A new `U` after release yields a normal `cmd_btn_u` pulse.
